// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-read-port register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NUM_RD = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: walks clr_ptr over every entry after reset or on clr_req.
// Ports: clk, rst_n (async active-low), clr_req (request re-clear while idle),
//        busy (clear in progress), clr_we (clear write strobe), clr_addr (entry to zero).
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_ptr;

  // State, pointer and busy flag; busy mirrors state so it is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == {ADDR_W{1'b1}}) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports with same-cycle
// write bypass, one clocked write port, optional hardwired zero entry and a
// sequenced hardware clear signalled by busy.
// Ports: rd_addr/rd_data packed per port (port k at [k*W +: W]); wr_en/wr_addr/wr_data
//        write port; clr_req re-clear request; busy clear in progress; wr_drop
//        combinational indication that a requested write is discarded.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = RF_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero;
  logic              wr_fire;

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes to the zero entry vanish silently; only busy/clr_req count as drops.
  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_fire = wr_en && !busy && !clr_req && !wr_zero;
  assign wr_drop = wr_en && (busy || clr_req);

  // Storage is not reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Per-port read mux; later assignments take priority.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem[addr];
      if (wr_fire && (wr_addr == addr)) data = wr_data;
      if ((ZERO_REG != 0) && (addr == '0)) data = '0;
      if (busy) data = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  typedef struct {
    int          tag;
    int          kind;
    int          port;
    int          id;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;
  logic        busy;
  logic        wr_drop;

  logic [11:0] rd_addr4;
  logic [63:0] rd_data4;
  logic        wr_en4;
  logic [2:0]  wr_addr4;
  logic [15:0] wr_data4;
  logic        clr_req4;
  logic        busy4;
  logic        wr_drop4;

  exp_t        q[$];
  int          cyc = 0;
  int          id_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  regfile_mp u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_req (clr_req),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  regfile_mp #(
    .DATA_W (16),
    .ADDR_W (3),
    .NUM_RD (4)
  ) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr4),
    .rd_data (rd_data4),
    .wr_en   (wr_en4),
    .wr_addr (wr_addr4),
    .wr_data (wr_data4),
    .clr_req (clr_req4),
    .busy    (busy4),
    .wr_drop (wr_drop4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fill_val(input int a);
    return 32'hA500_0000 | 32'(a * 32'h0101);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input int port, input logic [31:0] v);
    exp_t e;
    e.tag  = cyc;
    e.kind = kind;
    e.port = port;
    e.id   = id_cnt;
    e.val  = v;
    id_cnt++;
    q.push_back(e);
  endtask

  task automatic exp_all(input logic b, input logic d, input logic [31:0] r0, input logic [31:0] r1);
    expect_v(0, 0, 32'(b));
    expect_v(1, 0, 32'(d));
    expect_v(2, 0, r0);
    expect_v(2, 1, r1);
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Full clear: busy for 32 samples after the start cycle, low on the 33rd.
  task automatic run_clear(input logic drop);
    for (int i = 0; i < 32; i++) begin
      exp_all(1'b1, drop, 32'h0, 32'h0);
      step();
    end
    exp_all(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: compare every expectation due for the current cycle at the falling edge.
  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      m_e = q.pop_front();
      case (m_e.kind)
        0:       m_act = 32'(busy);
        1:       m_act = 32'(wr_drop);
        2:       m_act = rd_data[m_e.port*32 +: 32];
        3:       m_act = 32'(rd_data4[m_e.port*16 +: 16]);
        default: m_act = 32'(wr_drop4);
      endcase
      n_checks++;
      if (m_e.tag != cyc || m_act !== m_e.val) begin
        n_errors++;
        $display("FAIL chk%0d kind=%0d port=%0d cyc=%0d: got %h expected %h",
                 m_e.id, m_e.kind, m_e.port, cyc, m_act, m_e.val);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'h1234_5678;
    clr_req  = 1'b0;
    set_rd(5'd0, 5'd9);
    wr_en4   = 1'b0;
    wr_addr4 = 3'd0;
    wr_data4 = 16'h0;
    clr_req4 = 1'b0;
    rd_addr4 = {4{3'd7}};

    // Reset state with wr_en held high.
    step(); exp_all(1'b1, 1'b1, 32'h0, 32'h0);
    step(); exp_all(1'b1, 1'b1, 32'h0, 32'h0);

    // Release reset, wr_en still high (to the zero entry).
    step(); rst_n = 1'b1;
    run_clear(1'b1);

    // Zero register keeps reading 0 with wr_drop low.
    step(); exp_all(1'b0, 1'b0, 32'h0, 32'h0);

    // Same-cycle bypass, then storage.
    step(); wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; set_rd(5'd4, 5'd5);
    exp_all(1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    step(); wr_en = 1'b0;
    exp_all(1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);

    // Fill 1..31 through the bypass path.
    for (int a = 1; a < 32; a++) begin
      step(); wr_en = 1'b1; wr_addr = 5'(a); wr_data = fill_val(a); set_rd(5'(a), 5'd0);
      exp_all(1'b0, 1'b0, fill_val(a), 32'h0);
    end
    step(); wr_en = 1'b0; set_rd(5'd1, 5'd31);
    exp_all(1'b0, 1'b0, fill_val(1), fill_val(31));
    step(); set_rd(5'd5, 5'd17);
    exp_all(1'b0, 1'b0, fill_val(5), fill_val(17));

    // clr_req together with a write: clear wins, no bypass.
    step(); clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF; set_rd(5'd3, 5'd31);
    exp_all(1'b0, 1'b1, fill_val(3), fill_val(31));
    step(); clr_req = 1'b0; wr_en = 1'b0;
    run_clear(1'b0);
    for (int a = 1; a < 32; a++) begin
      step(); set_rd(5'(a), 5'(31 - a));
      exp_all(1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Reset in the middle of a clear restarts it from entry 0.
    step(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77; set_rd(5'd7, 5'd20);
    exp_all(1'b0, 1'b0, 32'h77, 32'h0);
    step(); wr_addr = 5'd20; wr_data = 32'h2020;
    exp_all(1'b0, 1'b0, 32'h77, 32'h2020);
    step(); wr_en = 1'b0;
    exp_all(1'b0, 1'b0, 32'h77, 32'h2020);
    step(); clr_req = 1'b1;
    exp_all(1'b0, 1'b0, 32'h77, 32'h2020);
    step(); clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_all(1'b1, 1'b0, 32'h0, 32'h0);
      step();
    end
    rst_n = 1'b0;
    exp_all(1'b1, 1'b0, 32'h0, 32'h0);
    step(); rst_n = 1'b1;
    run_clear(1'b0);
    step(); exp_all(1'b0, 1'b0, 32'h0, 32'h0);

    // Four-port, 8-entry, 16-bit instance.
    step(); wr_en4 = 1'b1; wr_addr4 = 3'd7; wr_data4 = 16'h00AA;
    for (int k = 0; k < 4; k++) expect_v(3, k, 32'h00AA);
    expect_v(4, 0, 32'h0);
    step(); wr_en4 = 1'b0;
    for (int k = 0; k < 4; k++) expect_v(3, k, 32'h00AA);
    step(); wr_en4 = 1'b1; wr_addr4 = 3'd0; wr_data4 = 16'h5555;
    rd_addr4 = {3'd0, 3'd7, 3'd0, 3'd7};
    expect_v(3, 0, 32'h00AA);
    expect_v(3, 1, 32'h0);
    expect_v(3, 2, 32'h00AA);
    expect_v(3, 3, 32'h0);
    expect_v(4, 0, 32'h0);
    step(); wr_en4 = 1'b0;
    step();
    step();

    if (q.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations never checked, required 0", q.size());
      n_errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the datapath, replacing the fixed 32x32, two-read-port, combinational-write register file. It adds:

- a clocked write port;
- same-cycle write-to-read bypass;
- an optional hardwired zero register;
- a sequenced hardware clear after reset or on request, signalled by `busy`.

It sits between decode (read addresses) and writeback (write port).

## Interface
- `DATA_W`, 32, word width in bits
- `ADDR_W`, 5, address width; `DEPTH = 2**ADDR_W` entries
- `NUM_RD`, 2, number of read ports, 1..4
- `ZERO_REG`, 1, if 1, entry 0 always reads 0 and ignores writes

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `rd_addr`  in  `NUM_RD*ADDR_W`  packed read addresses; port k uses bits `[k*ADDR_W +: ADDR_W]`
- `rd_data`  out  `NUM_RD*DATA_W`  packed read data, same packing
- `wr_en`  in  1  write request
- `wr_addr`  in  `ADDR_W`  write address
- `wr_data`  in  `DATA_W`  write data
- `clr_req`  in  1  single-cycle request to re-clear all entries
- `busy`  out  1  clear sequence in progress
- `wr_drop`  out  1  combinational; high when `wr_en` is high but the write is not performed

## Operation
- FSM states:
  - CLEAR: zero the entry at `clr_ptr`, then increment `clr_ptr`.
  - IDLE: normal operation.
- `rst_n` low:
  - async: state=CLEAR, `clr_ptr`=0, `busy`=1; memory contents are not reset directly.
- CLEAR:
  - Each rising edge writes 0 to `mem[clr_ptr]`.
  - When `clr_ptr` = `DEPTH-1`, the state goes to IDLE on that same edge.
  - `clr_ptr` wraps to 0.
- IDLE with `clr_req`=1: state=CLEAR, `clr_ptr`=0 on the next edge. `clr_req` is ignored while in CLEAR.
- Write: performed on a rising edge when `wr_en`=1, `busy`=0 and `clr_req`=0, and not (`ZERO_REG` and `wr_addr`=0).
- `wr_drop` = `wr_en` & (`busy` | `clr_req`). A write to address 0 with `ZERO_REG`=1 is silently ignored and does not raise `wr_drop`.
- Read is combinational and applies per port k, in priority order:
  1. `busy`=1 → 0.
  2. `ZERO_REG` and addr=0 → 0.
  3. Bypass: a write that will be performed this cycle to the same address → `wr_data`.
  4. Otherwise → `mem[addr]`.
- All read ports are independent. Any port may read any address, including duplicates.
- No arithmetic beyond the `clr_ptr` increment, which is `ADDR_W` bits wide and wraps modulo `DEPTH`.

## Timing
- Reset values: `busy`=1, `rd_data`=0 on every port, `wr_drop`=`wr_en`.
- Clear latency:
  - After `rst_n` rises, `busy` stays high for exactly `DEPTH` rising edges and falls after the `DEPTH`-th.
  - After `clr_req`, `busy` rises at the next edge, then stays high for `DEPTH` edges.
- Write latency: visible at a read port in the same cycle through the bypass; held in storage from the next edge onward.
- Read latency: 0 cycles, combinational from `rd_addr`.
- Simultaneous `wr_en` and `clr_req` in IDLE: clear wins, write dropped, `wr_drop`=1.
- Reset asserted mid-clear: `clr_ptr` restarts at 0 and a full `DEPTH`-cycle clear follows.
- Reset asserted mid-write: the write is lost.

## Structure
- Package `regfile_pkg`:
  - state enum `rf_state_t` {IDLE, CLEAR};
  - default parameter constants `RF_DATA_W`, `RF_ADDR_W`, `RF_NUM_RD`.
- Sub-module `regfile_clear_ctrl`: holds the FSM, `clr_ptr` and `busy`, and outputs the clear write strobe and address.
- Top level: storage array, write-enable muxing (clear vs. external), `NUM_RD` read/bypass muxes in a generate loop.

## Test plan
- Release reset, hold `wr_en`=1 throughout → `busy`=1 for 32 edges, `wr_drop`=1 for those 32 cycles; all ports read 0 then and afterwards.
- In IDLE write `0xDEADBEEF` to addr 5 while port 1 reads addr 5 → port 1 shows `0xDEADBEEF` in the same cycle; next cycle, with `wr_en`=0, still `0xDEADBEEF`.
- `ZERO_REG`=1: write `0x12345678` to addr 0 → every port reading addr 0 returns 0, `wr_drop`=0.
- Fill addrs 1..31 with distinct values, pulse `clr_req` together with `wr_en` to addr 3 → `wr_drop`=1, `busy` high for 32 edges, then all entries read 0.
- Assert `rst_n` low at clear cycle 10, release → clear restarts: `busy` high for a full 32 edges, and entries written before the reset read 0.
- `NUM_RD`=4, `ADDR_W`=3, `DATA_W`=16: write `0x00AA` to addr 7, all four ports read addr 7 → all return `0x00AA`.
